edc_window_buffer: RTL
======================

# edc_window_buffer

Streaming window generator that sits directly upstream of the EDC processing element. It accepts one D-bit binary feature-map pixel per handshake in raster order. It holds the last IN_WINDOW_H-1 image rows in line buffers and emits the IN_WINDOW_H × IN_WINDOW_W pixel window that the PE consumes as `data_in`, together with the `in_en` strobe. Windows are produced at the pooling pitch, so each emitted window yields one POOL_H × POOL_W output tile.

## Interface
- D, 512, bits per pixel (channel depth)
- FH, 3, kernel height
- FW, 3, kernel width
- POOL_H, 2, pooling height
- POOL_W, 2, pooling width
- STRIDE_H, 1, convolution vertical stride
- STRIDE_W, 1, convolution horizontal stride
- IMG_H, 32, frame height in pixels (≥ IN_WINDOW_H)
- IMG_W, 32, frame width in pixels (≥ IN_WINDOW_W)
- Derived: IN_WINDOW_H = (POOL_H-1)*STRIDE_H+FH, IN_WINDOW_W = (POOL_W-1)*STRIDE_W+FW, STEP_H = POOL_H*STRIDE_H, STEP_W = POOL_W*STRIDE_W, IN_WIDTH = D*IN_WINDOW_H*IN_WINDOW_W
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  pixel offered
- pix_ready  out  1  pixel accepted this cycle when high with pix_valid
- pix_data  in  D  pixel bits
- win_valid  out  1  window register holds an unconsumed window; drives PE `in_en`
- win_ready  in  1  downstream consumes window
- win_data  out  IN_WIDTH  window; pixel (r,c) at bits [IN_WIDTH-1-D*(r*IN_WINDOW_W+c) -: D]; r=0,c=0 is the top-left pixel, at the MSB
- win_last  out  1  qualifies win_valid: last window of frame
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- Accept = pix_valid && pix_ready. pix_ready = !win_valid || win_ready (single-entry output skid; no combinational path from pix_valid).
- Counters: col ∈ [0,IMG_W-1] and row ∈ [0,IMG_H-1] give the position of the next pixel to accept.
  - Each accept increments col.
  - At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and frame_done pulses on the next cycle.
- Line buffers: IN_WINDOW_H-1 rows of IMG_W × D bits. On each accept, the pixel at column col shifts down one row across all line buffers, and the new pixel enters the bottom row.
- Window shift register: IN_WINDOW_H × IN_WINDOW_W pixels.
  - On accept, every row shifts left by one column.
  - The rightmost column is loaded with line-buffer column col (oldest row on top) plus pix_data (bottom).
  - The register is not cleared at a row change. Stale columns are masked by the emit condition.
- Emit condition, evaluated on the accepted pixel:
  - row ≥ IN_WINDOW_H-1 and col ≥ IN_WINDOW_W-1, and
  - (row-(IN_WINDOW_H-1)) mod STEP_H == 0 and (col-(IN_WINDOW_W-1)) mod STEP_W == 0.
- When the emit condition holds, win_data is loaded from the post-shift window, win_valid is set, and win_last = (row == last emitting row && col == last emitting column).
- win_valid clears on win_ready unless a new window is loaded in the same cycle. On simultaneous consume and load, the new window wins and win_valid stays 1.
- Modulo tracking uses phase counters that reset at each row/frame start. There is no divider.

## Timing
- Latency: a window appears on win_* exactly 1 cycle after the accept of its bottom-right pixel.
- win_data and win_last are stable while win_valid && !win_ready.
- Backpressure: while win_valid && !win_ready, pix_ready = 0, so no pixels are lost and the counters freeze.
- Reset values: win_valid=0, win_last=0, frame_done=0, win_data=0, pix_ready=1, counters and phases = 0. Line-buffer contents are don't-care; they are masked by the emit condition.
- Reset mid-frame discards the partial frame and the pending window. The next accepted pixel is treated as (0,0).
- Back-to-back frames need no idle cycle. Pixel (0,0) of frame n+1 may be accepted the cycle after the last pixel of frame n.
- Throughput: 1 pixel/cycle with win_ready held high.

## Structure
- Shared package `edc_pkg`: the derived-width functions (IN_WINDOW_H/W, IN_WIDTH, STEP_H/W) and a pixel-index-to-bit-offset helper. The PE and this block use the same helper, so the two packings agree by construction.
- One sub-module, `edc_line_buffer`: a parameterised IMG_W × D shift/RAM row with a write-enable. It is instantiated IN_WINDOW_H-1 times as a cascade.
- Top level holds the counters, the window register, the emit logic and the output handshake. Target size is about 200-300 lines.

## Test plan
All scenarios use D=8, IMG_W=IMG_H=6, FH=FW=3, POOL 2×2, stride 1 (window 4×4, step 2), with pixel value = r*6+c.
- Continuous stream, win_ready=1 → exactly 4 windows, one cycle after accepts #21, #23, #33, #35. The first window's MSB byte is 0 and its LSB byte is 21. Only the 4th window has win_last=1. frame_done pulses once, the cycle after accept #35.
- win_ready=0 for 5 cycles after the first window → pix_ready stays low, win_data holds the first window unchanged, and the remaining windows match the continuous case.
- Random pix_valid gaps and random win_ready → window contents and order identical to the continuous case; no pixel dropped or duplicated.
- rst asserted after 14 accepts, then a full frame → outputs equal the reset values on the cycle after reset, followed by the same 4 windows as the continuous case.
- Two frames back-to-back (second frame values +100) → 8 windows. The first window of frame 2 has MSB byte 100 and contains no frame-1 pixels.
- Default parameters (D=512, 32×32) → 15×15 = 225 windows per frame. Each window matches the reference model of the PE input packing.

Source files
------------

// File: rtl/edc_pkg.sv
// rtl/edc_pkg.sv - derived window geometry and pixel packing shared by the window buffer and the PE
package edc_pkg;

  // Rows/columns of input pixels needed to produce one pooled output tile.
  function automatic int in_window(input int pool, input int stride, input int fk);
    return (pool - 1) * stride + fk;
  endfunction

  // Distance between consecutive emitted windows.
  function automatic int win_step(input int pool, input int stride);
    return pool * stride;
  endfunction

  function automatic int in_width(input int d, input int wh, input int ww);
    return d * wh * ww;
  endfunction

  // Counter width that also works for a range of one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of pixel (r,c) in the flattened window; (0,0) sits at the MSB.
  function automatic int pix_lsb(input int d, input int wh, input int ww, input int r, input int c);
    return d * wh * ww - d * (r * ww + c + 1);
  endfunction

endpackage

// File: rtl/edc_window_buffer_if.sv
// rtl/edc_window_buffer_if.sv - pixel-in / window-out handshake bundle
interface edc_window_buffer_if #(
  parameter int D        = 512,
  parameter int IN_WIDTH = D * 16
);
  logic                pix_valid;
  logic                pix_ready;
  logic [D-1:0]        pix_data;
  logic                win_valid;
  logic                win_ready;
  logic [IN_WIDTH-1:0] win_data;
  logic                win_last;
  logic                frame_done;

  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, win_last, frame_done
  );

  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data, win_last, frame_done
  );
endinterface

// File: rtl/edc_line_buffer.sv
// rtl/edc_line_buffer.sv - one image row of pixels, read-before-write at a single column
module edc_line_buffer
  import edc_pkg::*;
#(
  parameter int D     = 512,
  parameter int DEPTH = 32,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [D-1:0]  i_wdata,
  output logic [D-1:0]  o_rdata
);
  logic [D-1:0] r_mem [DEPTH];

  // Old content is read out combinationally while the new pixel replaces it.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/edc_window_buffer.sv
// rtl/edc_window_buffer.sv - raster pixel stream to pooled-pitch PE input windows
module edc_window_buffer
  import edc_pkg::*;
#(
  parameter int D        = 512,
  parameter int FH       = 3,
  parameter int FW       = 3,
  parameter int POOL_H   = 2,
  parameter int POOL_W   = 2,
  parameter int STRIDE_H = 1,
  parameter int STRIDE_W = 1,
  parameter int IMG_H    = 32,
  parameter int IMG_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  edc_window_buffer_if.slave bus
);
  localparam int WH       = in_window(POOL_H, STRIDE_H, FH);
  localparam int WW       = in_window(POOL_W, STRIDE_W, FW);
  localparam int SH       = win_step(POOL_H, STRIDE_H);
  localparam int SW       = win_step(POOL_W, STRIDE_W);
  localparam int IN_WIDTH = in_width(D, WH, WW);
  localparam int LB_N     = WH - 1;
  localparam int CW       = idx_width(IMG_W);
  localparam int RW       = idx_width(IMG_H);
  localparam int PCW      = idx_width(SW);
  localparam int PRW      = idx_width(SH);

  localparam logic [CW-1:0]  COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0]  COL_FIRST     = CW'(WW - 1);
  localparam logic [RW-1:0]  ROW_FIRST     = RW'(WH - 1);
  localparam logic [CW-1:0]  COL_EMIT_LAST = CW'(WW - 1 + ((IMG_W - WW) / SW) * SW);
  localparam logic [RW-1:0]  ROW_EMIT_LAST = RW'(WH - 1 + ((IMG_H - WH) / SH) * SH);
  localparam logic [PCW-1:0] PC_LAST       = PCW'(SW - 1);
  localparam logic [PRW-1:0] PR_LAST       = PRW'(SH - 1);

  logic [CW-1:0]                  r_col;
  logic [RW-1:0]                  r_row;
  logic [PCW-1:0]                 r_col_ph;
  logic [PRW-1:0]                 r_row_ph;
  logic                           r_win_valid;
  logic                           r_win_last;
  logic                           r_frame_done;
  logic [IN_WIDTH-1:0]            r_win_data;
  logic [WH-1:0][WW-1:0][D-1:0]   r_win;

  logic                           w_accept;
  logic                           w_col_end;
  logic                           w_row_end;
  logic                           w_emit;
  logic                           w_emit_last;
  logic [WH-1:0][D-1:0]           w_col_in;
  logic [WH-1:0][WW-1:0][D-1:0]   w_win_next;
  logic [IN_WIDTH-1:0]            w_win_flat;

  assign bus.pix_ready  = !r_win_valid || bus.win_ready;
  assign w_accept       = bus.pix_valid && bus.pix_ready;
  assign w_col_end      = (r_col == COL_LAST);
  assign w_row_end      = (r_row == ROW_LAST);
  assign w_emit         = (r_row >= ROW_FIRST) && (r_col >= COL_FIRST) &&
                          (r_row_ph == '0) && (r_col_ph == '0);
  assign w_emit_last    = (r_row == ROW_EMIT_LAST) && (r_col == COL_EMIT_LAST);

  assign bus.win_valid  = r_win_valid;
  assign bus.win_last   = r_win_last;
  assign bus.win_data   = r_win_data;
  assign bus.frame_done = r_frame_done;

  // Cascade: each row hands its old pixel at this column to the row above it.
  assign w_col_in[WH-1] = bus.pix_data;
  for (genvar i = 0; i < LB_N; i++) begin : g_lb
    edc_line_buffer #(
      .D     (D),
      .DEPTH (IMG_W),
      .AW    (CW)
    ) u_lb (
      .clk     (clk),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (w_col_in[i+1]),
      .o_rdata (w_col_in[i])
    );
  end

  // Post-shift window: every row moves left, the fresh column enters on the right.
  always_comb begin
    w_win_next = r_win;
    for (int r = 0; r < WH; r++) begin
      for (int c = 0; c < WW - 1; c++) w_win_next[r][c] = r_win[r][c+1];
      w_win_next[r][WW-1] = w_col_in[r];
    end
  end

  // Pack the post-shift window with the same layout the PE unpacks.
  always_comb begin
    w_win_flat = '0;
    for (int r = 0; r < WH; r++)
      for (int c = 0; c < WW; c++)
        w_win_flat[pix_lsb(D, WH, WW, r, c) +: D] = w_win_next[r][c];
  end

  // Window shift register; stale columns after a row change are never emitted.
  always_ff @(posedge clk) begin
    if (w_accept) r_win <= w_win_next;
  end

  // Position/phase counters and the single-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_col_ph     <= '0;
      r_row_ph     <= '0;
      r_win_valid  <= 1'b0;
      r_win_last   <= 1'b0;
      r_win_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_col_end && w_row_end;
      if (w_accept) begin
        if (w_col_end) begin
          r_col    <= '0;
          r_col_ph <= '0;
          if (w_row_end) begin
            r_row    <= '0;
            r_row_ph <= '0;
          end else begin
            r_row <= r_row + 1'b1;
            if (r_row < ROW_FIRST) r_row_ph <= '0;
            else                   r_row_ph <= (r_row_ph == PR_LAST) ? '0 : r_row_ph + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
          if (r_col < COL_FIRST) r_col_ph <= '0;
          else                   r_col_ph <= (r_col_ph == PC_LAST) ? '0 : r_col_ph + 1'b1;
        end
      end
      if (w_accept && w_emit) begin
        r_win_valid <= 1'b1;
        r_win_data  <= w_win_flat;
        r_win_last  <= w_emit_last;
      end else if (bus.win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end
endmodule
